mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped peripheral responder for the MIPS CPU memory bus (CS, WE, ADDR[6:0], bidirectional 32-bit Mem_Bus). It claims the top eight word addresses, 7'h78–7'h7F, and answers CPU `lw`/`sw` accesses there. It provides an output port, a synchronized input port, an 8-deep byte TX FIFO with a valid/ready drain port, and an optional cycle timer with interrupt. It sits between the CPU and the Memory block and gates Memory's chip select, so the two never drive Mem_Bus at the same time.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries, power of two.
- `BASE`, default 7'h78: window base, 8-word aligned.
- `CLK` in 1: system clock. All block state updates on negedge, matching Memory.
- `RST` in 1: reset, asynchronous, active-high.
- `CS` in 1: CPU chip select.
- `WE` in 1: CPU write enable.
- `ADDR` in 7: CPU word address.
- `Mem_Bus` inout 32: shared data bus.
- `MEM_CS` out 1: chip select to Memory, equal to `CS & ~hit`.
- `DIN` in 16: asynchronous external input.
- `DOUT` out 16: output port register.
- `TX_DATA` out 8: FIFO head.
- `TX_VALID` out 1: FIFO non-empty.
- `TX_READY` in 1: consumer accepts the head.
- `IRQ` out 1: timer interrupt, level.

## Operation
- Window decode: `hit = (ADDR[6:3] == BASE[6:3])`, combinational.
- Bus drive: the block drives Mem_Bus with `rdata` only when `CS & ~WE & hit`; otherwise it drives Z.
- `rdata` is registered. It loads at every negedge from the register selected by ADDR[2:0]; unused bits read 0.
- Writes are taken on the negedge where `CS & WE & hit`, with data from Mem_Bus.
- Register map (offsets from BASE):
  - +0 OUT: R/W. Write sets DOUT = Mem_Bus[15:0].
  - +1 IN: RO. DIN through a 2-flop synchronizer, zero-extended.
  - +2 TXD: WO. Write pushes Mem_Bus[7:0]. A read returns 0.
  - +3 STATUS, read bits:
    - [0] empty
    - [1] full
    - [7:4] count
    - [8] overflow (sticky)
    - [9] timer hit (sticky)
  - +3 STATUS, write: W1C on bits 8 and 9.
  - +4 TCOUNT: R/W, 32-bit. A write loads the counter.
  - +5 TCMP: R/W, 32-bit.
  - +6 TCTRL: R/W.
    - [0] timer enable
    - [1] IRQ enable
  - +7: reads 0, writes ignored.
- FIFO behaviour:
  - Push while full: data dropped, overflow set, contents unchanged.
  - Pop when `TX_VALID & TX_READY` at a negedge.
  - Push and pop on the same edge: both take effect and count is unchanged. This holds even when full, because the pop frees the slot first.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap. Count is log2(FIFO_DEPTH)+1 bits wide.
- Timer:
  - When enabled, TCOUNT increments by 1 per negedge and wraps at 2^32.
  - A TCOUNT write overrides the increment on that edge.
  - When the incremented value equals TCMP, hit is set.
  - `IRQ = hit & irq_en`.

## Timing
- Reset values:
  - DOUT=0, rdata=0, FIFO empty (TX_VALID=0, TX_DATA=0)
  - overflow=0, hit=0, IRQ=0
  - TCOUNT=0, TCMP=32'hFFFFFFFF, TCTRL=0, synchronizer=0
  - MEM_CS stays combinational during reset.
- Reset mid-operation clears everything immediately (asynchronous). A bus write on that edge is lost.
- Read latency matches Memory: rdata is sampled at the negedge inside the CPU cycle that asserts CS with ADDR. It is valid on Mem_Bus for the following posedge.
- DIN-to-IN latency: 2 negedges.
- Write-to-DOUT: DOUT updates at the negedge the write is sampled.
- Pop: TX_DATA shows the next entry after that negedge.
- STATUS read in the same cycle as a push reflects the pre-push state.
- Status W1C coinciding with a new set event: set wins.

## Configuration
- `MMIO_TIMER_EN` defined: timer registers, the hit bit, and IRQ are present as described.
- `MMIO_TIMER_EN` undefined:
  - +4/+5/+6 read 0 and ignore writes.
  - STATUS[9]=0 and IRQ is tied to 0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- RST pulse during a FIFO push: all outputs go to their reset values immediately. Access to ADDR=7'h77 gives MEM_CS=CS; access to 7'h78 gives MEM_CS=0.
- `sw` 32'h00001234 to 7'h78, then `lw` 7'h78: DOUT=16'h1234 after the write negedge; the read returns 32'h00001234. Memory is never selected during either access.
- TX_READY=0, push 9 bytes 8'h01..8'h09: STATUS reads 32'h00000182 (full, count=8, overflow). Then TX_READY=1: 01..08 pop, one per negedge, then TX_VALID=0.
- FIFO full and TX_READY=1, push 8'hAA on the same edge as a pop: count stays 8, overflow not set, 8'hAA exits last.
- With timer: TCMP=5, TCTRL=3, TCOUNT=0: IRQ rises at the 5th enabled negedge. Writing 32'h200 to STATUS drops IRQ unless a new hit occurs on that edge.
- DIN changes 16'h0000→16'hBEEF: an IN read returns 16'h0000 until 2 negedges have passed, then 32'h0000BEEF.

Source files
------------

// File: rtl/mmio_responder_if.sv
// TX drain port of mmio_responder: byte stream with valid/ready handshake.
// master = the responder (producer), slave = the byte consumer.
interface mmio_responder_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder at the top of the MIPS bus window: OUT/IN ports, TX FIFO,
// and a cycle timer with IRQ that exists only when MMIO_TIMER_EN is defined.
module mmio_responder #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [6:0] BASE       = 7'h78
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [6:0]  ADDR,
  inout  wire  [31:0] Mem_Bus,
  output logic        MEM_CS,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  mmio_responder_if.master tx,
  output logic        IRQ
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic        hit;
  logic        wr;
  logic [2:0]  off;
  logic [31:0] wdata;

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] sync1_q, sync2_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        empty, full;
  logic        pop, push_req, push, ovf_set;
  logic        st_wr;
  logic [31:0] status;
  logic        thit;

  assign hit    = (ADDR[6:3] == BASE[6:3]);
  assign MEM_CS = CS & ~hit;
  assign wr     = CS & WE & hit;
  assign off    = ADDR[2:0];
  assign wdata  = Mem_Bus;

  // Only drive the shared bus while Memory is deselected and the CPU reads.
  assign Mem_Bus = (CS & ~WE & hit) ? rdata_q : 'z;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign st_wr = wr & (off == 3'd3);

  assign tx.TX_VALID = ~empty;
  assign tx.TX_DATA  = empty ? 8'h00 : mem_q[rptr_q];
  assign DOUT        = dout_q;

  // A pop on the same edge frees the slot, so a push into a full FIFO lands.
  always_comb begin
    pop      = ~empty & tx.TX_READY;
    push_req = wr & (off == 3'd2);
    push     = push_req & (~full | pop);
    ovf_set  = push_req & full & ~pop;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wptr_q] = wdata[7:0];
    end
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = ovf_q;
    if (st_wr & wdata[8]) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    dout_d = dout_q;
    if (wr & (off == 3'd0)) begin
      dout_d = wdata[15:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [1:0]  tctrl_q, tctrl_d;
  logic        thit_q, thit_d;
  logic [31:0] tinc;
  logic        thit_set;

  always_comb begin
    tinc     = tcount_q + 32'd1;
    tcount_d = tcount_q;
    thit_set = 1'b0;
    if (wr & (off == 3'd4)) begin
      tcount_d = wdata;
    end else if (tctrl_q[0]) begin
      tcount_d = tinc;
      thit_set = (tinc == tcmp_q);
    end
    tcmp_d = tcmp_q;
    if (wr & (off == 3'd5)) begin
      tcmp_d = wdata;
    end
    tctrl_d = tctrl_q;
    if (wr & (off == 3'd6)) begin
      tctrl_d = wdata[1:0];
    end
    thit_d = thit_q;
    if (st_wr & wdata[9]) begin
      thit_d = 1'b0;
    end
    if (thit_set) begin
      thit_d = 1'b1;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      tcount_q <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      tctrl_q  <= '0;
      thit_q   <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      tctrl_q  <= tctrl_d;
      thit_q   <= thit_d;
    end
  end

  assign thit = thit_q;
  assign IRQ  = thit_q & tctrl_q[1];
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];
  assign thit = 1'b0;
  assign IRQ  = 1'b0;
`endif

  always_comb begin
    status      = '0;
    status[0]   = empty;
    status[1]   = full;
    status[7:4] = 4'(cnt_q);
    status[8]   = ovf_q;
    status[9]   = thit;
  end

  always_comb begin
    rdata_d = '0;
    case (off)
      3'd0: rdata_d[15:0] = dout_q;
      3'd1: rdata_d[15:0] = sync2_q;
      3'd3: rdata_d = status;
`ifdef MMIO_TIMER_EN
      3'd4: rdata_d = tcount_q;
      3'd5: rdata_d = tcmp_q;
      3'd6: rdata_d[1:0] = tctrl_q;
`endif
      default: rdata_d = '0;
    endcase
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      rdata_q <= '0;
      dout_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      sync1_q <= DIN;
      sync2_q <= sync1_q;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: TX_DATA is masked while the FIFO is empty.
  always_ff @(negedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: CPU-style lw/sw cycles push expected
// read data and TX bytes into queues; monitors pop and compare.
module tb_mmio_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CS = 1'b0;
  logic        WE = 1'b0;
  logic [6:0]  ADDR = '0;
  logic [15:0] DIN = '0;
  wire  [31:0] Mem_Bus;
  logic        MEM_CS;
  logic [15:0] DOUT;
  logic        IRQ;
  logic        bus_oe = 1'b0;
  logic [31:0] bus_wd = '0;

  int vec = 0;
  int bad = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] rexp;
  logic [7:0]  texp;

  assign Mem_Bus = bus_oe ? bus_wd : 'z;

  mmio_responder_if txi ();

  mmio_responder dut (
    .CLK     (CLK),
    .RST     (RST),
    .CS      (CS),
    .WE      (WE),
    .ADDR    (ADDR),
    .Mem_Bus (Mem_Bus),
    .MEM_CS  (MEM_CS),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .tx      (txi),
    .IRQ     (IRQ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    CS = 1'b1; WE = 1'b1; ADDR = a;
    bus_wd = d; bus_oe = 1'b1;
    #1;
    check("mem_cs_wr", 32'(MEM_CS), 32'(a[6:3] != 4'hF));
    @(negedge CLK);
    #2;
    CS = 1'b0; WE = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    @(posedge CLK);
    #1;
    CS = 1'b1; WE = 1'b0; ADDR = a;
    #1;
    check("mem_cs_rd", 32'(MEM_CS), 32'(a[6:3] != 4'hF));
    @(negedge CLK);
    #2;
    CS = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  // Read data is valid on the bus just after the sampling negedge.
  always @(negedge CLK) begin
    #1;
    if (CS && !WE && ADDR[6:3] == 4'hF) begin
      if (rd_q.size() == 0) begin
        vec++; bad++;
        $display("FAIL rd_unexpected: got %h want none", Mem_Bus);
      end else begin
        rexp = rd_q.pop_front();
        check("rd_data", Mem_Bus, rexp);
      end
    end
  end

  // A handshake seen mid-high-phase pops at the coming negedge.
  always @(posedge CLK) begin
    #3;
    if (txi.TX_VALID && txi.TX_READY) begin
      if (tx_q.size() == 0) begin
        vec++; bad++;
        $display("FAIL tx_unexpected: got %h want none", txi.TX_DATA);
      end else begin
        texp = tx_q.pop_front();
        check("tx_data", 32'(txi.TX_DATA), 32'(texp));
      end
    end
  end

  initial begin
    txi.TX_READY = 1'b0;
    #3;
    check("rst_dout", 32'(DOUT), 32'h0);
    check("rst_valid", 32'(txi.TX_VALID), 32'h0);
    check("rst_txdata", 32'(txi.TX_DATA), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    rd(7'h7B, 32'h0000_0001);

    // reset pulse during a push
    wr(7'h78, 32'h0000_0055);
    wr(7'h7A, 32'h33);
    wr(7'h7A, 32'h44);
    check("pre_rst_valid", 32'(txi.TX_VALID), 32'h1);
    @(posedge CLK);
    #1;
    CS = 1'b1; WE = 1'b1; ADDR = 7'h7A;
    bus_wd = 32'h99; bus_oe = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    check("arst_valid", 32'(txi.TX_VALID), 32'h0);
    check("arst_txdata", 32'(txi.TX_DATA), 32'h0);
    check("arst_dout", 32'(DOUT), 32'h0);
    check("arst_irq", 32'(IRQ), 32'h0);
    @(negedge CLK);
    #2;
    CS = 1'b0; WE = 1'b0; bus_oe = 1'b0;
    ADDR = 7'h77; CS = 1'b1;
    #1;
    check("memcs_77", 32'(MEM_CS), 32'h1);
    ADDR = 7'h78;
    #1;
    check("memcs_78", 32'(MEM_CS), 32'h0);
    CS = 1'b0;
    RST = 1'b0;
    rd(7'h7B, 32'h0000_0001);
    rd(7'h78, 32'h0000_0000);

    // OUT port
    wr(7'h78, 32'h0000_1234);
    check("dout_1234", 32'(DOUT), 32'h1234);
    rd(7'h78, 32'h0000_1234);
    rd(7'h7F, 32'h0);
    rd(7'h7A, 32'h0);

    // overflow: nine pushes into eight slots
    for (int i = 1; i <= 9; i++) begin
      wr(7'h7A, 32'(i));
      if (i <= 8) tx_q.push_back(8'(i));
    end
    rd(7'h7B, 32'h0000_0182);
    txi.TX_READY = 1'b1;
    idle(9);
    check("drain1_valid", 32'(txi.TX_VALID), 32'h0);
    wr(7'h7B, 32'h0000_0100);
    rd(7'h7B, 32'h0000_0001);

    // push into full FIFO on the same edge as a pop
    txi.TX_READY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(7'h7A, 32'(8'h10 + i));
      tx_q.push_back(8'(8'h10 + i));
    end
    txi.TX_READY = 1'b1;
    wr(7'h7A, 32'h0000_00AA);
    tx_q.push_back(8'hAA);
    txi.TX_READY = 1'b0;
    rd(7'h7B, 32'h0000_0082);
    txi.TX_READY = 1'b1;
    idle(9);
    check("drain2_valid", 32'(txi.TX_VALID), 32'h0);

    // synchronizer latency
    DIN = 16'hBEEF;
    rd(7'h79, 32'h0000_0000);
    rd(7'h79, 32'h0000_0000);
    rd(7'h79, 32'h0000_BEEF);

`ifdef MMIO_TIMER_EN
    rd(7'h7D, 32'hFFFF_FFFF);
    wr(7'h7D, 32'd5);
    wr(7'h7C, 32'd0);
    wr(7'h7E, 32'd3);
    idle(4);
    check("irq_before", 32'(IRQ), 32'h0);
    idle(1);
    check("irq_hit", 32'(IRQ), 32'h1);
    rd(7'h7B, 32'h0000_0201);
    wr(7'h7B, 32'h0000_0200);
    check("irq_w1c", 32'(IRQ), 32'h0);
    wr(7'h7C, 32'd0);
    idle(5);
    check("irq_hit2", 32'(IRQ), 32'h1);
    wr(7'h7C, 32'd3);
    idle(1);
    wr(7'h7B, 32'h0000_0200);
    check("irq_set_wins", 32'(IRQ), 32'h1);
    wr(7'h7B, 32'h0000_0200);
    check("irq_w1c2", 32'(IRQ), 32'h0);
    rd(7'h7D, 32'd5);
    rd(7'h7E, 32'd3);
    wr(7'h7E, 32'd0);
`else
    rd(7'h7C, 32'h0);
    rd(7'h7D, 32'h0);
    wr(7'h7E, 32'd3);
    wr(7'h7D, 32'd1);
    idle(3);
    rd(7'h7E, 32'h0);
    check("irq_off", 32'(IRQ), 32'h0);
    rd(7'h7B, 32'h0000_0001);
`endif

    idle(3);
    check("rd_q_empty", 32'(rd_q.size()), 32'h0);
    check("tx_q_empty", 32'(tx_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
